// File: rtl/nmac_port_arbiter.sv
// nmac_port_arbiter: round-robin merge of the per-port CRC-checked packet/valid FIFO pairs into
// one shared output packet/valid FIFO pair. Packets whose valid word is 1 are forwarded, packets
// whose valid word is 0 are drained. Per-block forward and drop counters saturate at 16'hFFFF.
module nmac_port_arbiter #(
  parameter int unsigned PORTS        = 4,
  parameter logic [7:0]  USEDW_THRESH = 8'd161
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORTS*139-1:0] in_pkt_q,
  input  logic [PORTS-1:0]     in_pkt_empty,
  output logic [PORTS-1:0]     in_pkt_rdreq,
  input  logic [PORTS-1:0]     in_valid_q,
  input  logic [PORTS-1:0]     in_valid_empty,
  output logic [PORTS-1:0]     in_valid_rdreq,
  output logic                 out_pkt_wrreq,
  output logic [138:0]         out_pkt,
  input  logic [7:0]           out_pkt_usedw,
  output logic                 out_valid_wrreq,
  output logic                 out_valid,
  output logic [2:0]           grant,
  output logic [15:0]          fwd_cnt,
  output logic [15:0]          drop_cnt
);

  localparam logic [3:0] PortsW   = 4'(PORTS);
  localparam logic [2:0] LastPort = 3'(PORTS - 1);

  typedef enum logic [2:0] {StIdle, StSel, StXfer, StDrop, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       grant_q, grant_d;
  logic             fwd_q, fwd_d;  // valid word of the owned packet
  logic [PORTS-1:0] vrd_q, vrd_d;
  logic [138:0]     out_pkt_q, out_pkt_d;
  logic             out_pkt_wrreq_q, out_pkt_wrreq_d;
  logic             out_valid_wrreq_q, out_valid_wrreq_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      fwd_cnt_q, fwd_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [PORTS-1:0] pkt_rd;

  logic             win_found;
  logic [2:0]       win_idx;
  logic             win_vld;
  logic [3:0]       cand;
  logic [138:0]     head;
  logic             head_empty;

  // Round-robin search: first port with a non-empty valid FIFO at or after rr_ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(PORTS); k++) begin
      cand = {1'b0, rr_ptr_q} + 4'(k);
      if (cand >= PortsW) cand = cand - PortsW;
      for (int i = 0; i < int'(PORTS); i++) begin
        if (!win_found && (cand == 4'(i)) && !in_valid_empty[i]) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  // Per-port muxes: winner's valid word, and the granted packet FIFO head/empty.
  always_comb begin
    win_vld    = 1'b0;
    head       = '0;
    head_empty = 1'b1;
    for (int i = 0; i < int'(PORTS); i++) begin
      if (win_idx == 3'(i)) win_vld = in_valid_q[i];
      if (grant_q == 3'(i)) begin
        head       = in_pkt_q[139*i +: 139];
        head_empty = in_pkt_empty[i];
      end
    end
  end

  // Next-state logic and strobes.
  always_comb begin
    state_d           = state_q;
    rr_ptr_d          = rr_ptr_q;
    grant_d           = grant_q;
    fwd_d             = fwd_q;
    vrd_d             = '0;
    pkt_rd            = '0;
    out_pkt_d         = out_pkt_q;
    out_pkt_wrreq_d   = 1'b0;
    out_valid_wrreq_d = 1'b0;
    out_valid_d       = out_valid_q;
    fwd_cnt_d         = fwd_cnt_q;
    drop_cnt_d        = drop_cnt_q;
    unique case (state_q)
      StIdle: begin
        // Threshold gates only packets that will be forwarded; no skipping past a blocked winner.
        if (win_found && !(win_vld && (out_pkt_usedw >= USEDW_THRESH))) begin
          grant_d = win_idx;
          fwd_d   = win_vld;
          for (int i = 0; i < int'(PORTS); i++) vrd_d[i] = (win_idx == 3'(i));
          state_d = StSel;
        end
      end
      StSel: begin
        state_d = fwd_q ? StXfer : StDrop;
      end
      StXfer, StDrop: begin
        if (!head_empty) begin
          for (int i = 0; i < int'(PORTS); i++) pkt_rd[i] = (grant_q == 3'(i));
          if (state_q == StXfer) begin
            out_pkt_d       = head;
            out_pkt_wrreq_d = 1'b1;
          end
          // 110 tail or 111 single-word ends the packet.
          if (head[138:137] == 2'b11) state_d = StDone;
        end
      end
      StDone: begin
        if (fwd_q) begin
          out_valid_wrreq_d = 1'b1;
          out_valid_d       = 1'b1;
          if (fwd_cnt_q != 16'hFFFF) fwd_cnt_d = fwd_cnt_q + 16'd1;
        end else begin
          if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
        rr_ptr_d = (grant_q == LastPort) ? 3'd0 : grant_q + 3'd1;
        grant_d  = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      rr_ptr_q          <= '0;
      grant_q           <= '0;
      fwd_q             <= 1'b0;
      vrd_q             <= '0;
      out_pkt_q         <= '0;
      out_pkt_wrreq_q   <= 1'b0;
      out_valid_wrreq_q <= 1'b0;
      out_valid_q       <= 1'b0;
      fwd_cnt_q         <= '0;
      drop_cnt_q        <= '0;
    end else begin
      state_q           <= state_d;
      rr_ptr_q          <= rr_ptr_d;
      grant_q           <= grant_d;
      fwd_q             <= fwd_d;
      vrd_q             <= vrd_d;
      out_pkt_q         <= out_pkt_d;
      out_pkt_wrreq_q   <= out_pkt_wrreq_d;
      out_valid_wrreq_q <= out_valid_wrreq_d;
      out_valid_q       <= out_valid_d;
      fwd_cnt_q         <= fwd_cnt_d;
      drop_cnt_q        <= drop_cnt_d;
    end
  end

  assign in_pkt_rdreq    = pkt_rd;
  assign in_valid_rdreq  = vrd_q;
  assign out_pkt_wrreq   = out_pkt_wrreq_q;
  assign out_pkt         = out_pkt_q;
  assign out_valid_wrreq = out_valid_wrreq_q;
  assign out_valid       = out_valid_q;
  assign grant           = grant_q;
  assign fwd_cnt         = fwd_cnt_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_nmac_port_arbiter.sv
// tb_nmac_port_arbiter: show-ahead FIFO models around the arbiter, a grant-decision vector table,
// directed multi-cycle sequences and randomized traffic checked against a packet-level
// round-robin reference model.
module tb_nmac_port_arbiter;
  localparam int P  = 4;
  localparam int D  = 512;
  localparam int NK = 128;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [P*139-1:0] in_pkt_q;
  logic [P-1:0]   in_pkt_empty, in_pkt_rdreq, in_valid_q, in_valid_empty, in_valid_rdreq;
  logic           out_pkt_wrreq, out_valid_wrreq, out_valid;
  logic [138:0]   out_pkt;
  logic [7:0]     out_pkt_usedw;
  logic [2:0]     grant;
  logic [15:0]    fwd_cnt, drop_cnt;

  nmac_port_arbiter #(.PORTS(P), .USEDW_THRESH(8'd161)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_pkt_q       (in_pkt_q),
    .in_pkt_empty   (in_pkt_empty),
    .in_pkt_rdreq   (in_pkt_rdreq),
    .in_valid_q     (in_valid_q),
    .in_valid_empty (in_valid_empty),
    .in_valid_rdreq (in_valid_rdreq),
    .out_pkt_wrreq  (out_pkt_wrreq),
    .out_pkt        (out_pkt),
    .out_pkt_usedw  (out_pkt_usedw),
    .out_valid_wrreq(out_valid_wrreq),
    .out_valid      (out_valid),
    .grant          (grant),
    .fwd_cnt        (fwd_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // Input FIFO storage (write/read indices only grow; reset clears them).
  logic [138:0] pmem [P][D];
  logic         vmem [P][D];
  int           pwr [P], prd [P], vwr [P], vrd [P];
  logic [P-1:0] hide;
  bit           rand_used, rand_hide, mon_en;

  // Reference model: per-port packet lists and round-robin pointer.
  int           m_len [P][NK];
  bit           m_val [P][NK];
  int           npk [P], m_pk [P], m_woff [P];
  int           m_ptr, m_fwd, m_drop;
  logic [138:0] expq [$];
  int           expg [$];

  int           nchk, npass, cycle, nvalid, last_vrd_cyc, wr_lat;
  bit           await_wr, prev_tail, s_wr;
  logic [P-1:0] s_prd, s_vrd, s_pe, s_ve;

  typedef struct packed {
    logic [P-1:0] vempty;
    logic [P-1:0] vq;
    logic [7:0]   used;
    logic         granted;
    logic [2:0]   g;
  } gvec_t;
  gvec_t tbl [8];

  task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic drive();
    for (int i = 0; i < P; i++) begin
      in_pkt_empty[i]        = (pwr[i] == prd[i]) || hide[i];
      in_pkt_q[139*i +: 139] = pmem[i][prd[i] % D];
      in_valid_empty[i]      = (vwr[i] == vrd[i]);
      in_valid_q[i]          = vmem[i][vrd[i] % D];
    end
  endtask

  task automatic monitor();
    bit           ok;
    int           g;
    logic [P-1:0] e;
    ok = ($countones({s_prd, s_vrd}) <= 1) && ((s_prd & s_pe) == '0) && ((s_vrd & s_ve) == '0);
    chk("rdreq_protocol", 139'(ok), 139'(1));
    if (s_vrd != '0) begin
      last_vrd_cyc = cycle;
      await_wr     = 1'b1;
      if (expg.size() == 0) chk("grant_order_extra", 139'(s_vrd), 139'(0));
      else begin
        g = expg.pop_front();
        e = '0;
        e[g] = 1'b1;
        chk("grant_order", 139'(grant), 139'(g));
        chk("valid_rdreq", 139'(s_vrd), 139'(e));
      end
    end
    if (out_pkt_wrreq) begin
      if (await_wr) begin
        wr_lat   = cycle - last_vrd_cyc;
        await_wr = 1'b0;
      end
      if (expq.size() == 0) chk("out_pkt_extra", 139'(out_pkt_wrreq), 139'(0));
      else chk("out_pkt", out_pkt, expq.pop_front());
    end
    if (out_valid_wrreq) begin
      nvalid++;
      chk("valid_after_tail", 139'({out_valid, prev_tail}), 139'(2'b11));
    end
    prev_tail = out_pkt_wrreq && (out_pkt[138:137] == 2'b11);
  endtask

  // One clock: sample at negedge, apply FIFO pops and new inputs just after posedge.
  task automatic cyc();
    @(negedge clk);
    cycle++;
    s_prd = in_pkt_rdreq;
    s_vrd = in_valid_rdreq;
    s_pe  = in_pkt_empty;
    s_ve  = in_valid_empty;
    s_wr  = out_pkt_wrreq;
    if (mon_en) monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++) begin
      if (s_prd[i] && (prd[i] != pwr[i])) prd[i]++;
      if (s_vrd[i] && (vrd[i] != vwr[i])) vrd[i]++;
      if (rand_hide) hide[i] = ($urandom_range(0, 3) == 0);
    end
    if (rand_used) out_pkt_usedw = 8'($urandom_range(155, 165));
    drive();
  endtask

  task automatic add_pkt(input int p, input bit v, input int len, input int bc);
    logic [2:0]   t;
    logic [3:0]   b;
    logic [138:0] word;
    for (int w = 0; w < len; w++) begin
      t = (len == 1) ? 3'b111 : (w == 0) ? 3'b101 : (w == len - 1) ? 3'b110 : 3'b100;
      b = 4'($urandom_range(0, 15));
      if (t[2:1] == 2'b11 && bc >= 0) b = 4'(bc);
      word = {t, b, $urandom, $urandom, $urandom, $urandom, 4'($urandom)};
      pmem[p][pwr[p] % D] = word;
      pwr[p]++;
    end
    vmem[p][vwr[p] % D] = v;
    vwr[p]++;
    m_len[p][npk[p]] = len;
    m_val[p][npk[p]] = v;
    npk[p]++;
    drive();
  endtask

  // Serve pending packets in round-robin order from m_ptr, building expected grants and words.
  task automatic model_run();
    int p, c;
    bit found;
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      p     = 0;
      for (int k = 0; k < P; k++) begin
        c = (m_ptr + k) % P;
        if (!found && (m_pk[c] < npk[c])) begin
          found = 1'b1;
          p     = c;
        end
      end
      if (found) begin
        expg.push_back(p);
        if (m_val[p][m_pk[p]]) begin
          for (int w = 0; w < m_len[p][m_pk[p]]; w++) expq.push_back(pmem[p][(m_woff[p] + w) % D]);
          m_fwd++;
        end else m_drop++;
        m_woff[p] += m_len[p][m_pk[p]];
        m_pk[p]++;
        m_ptr = (p + 1) % P;
      end
    end
  endtask

  task automatic run_until(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !(expq.size() == 0 && expg.size() == 0 && nvalid == m_fwd &&
                           fwd_cnt == 16'(m_fwd) && drop_cnt == 16'(m_drop))) begin
      cyc();
      n++;
    end
    chk({name, "_in_budget"}, 139'(n < budget), 139'(1));
    cyc();
    cyc();
    chk({name, "_fwd_cnt"}, 139'(fwd_cnt), 139'(m_fwd));
    chk({name, "_drop_cnt"}, 139'(drop_cnt), 139'(m_drop));
    chk({name, "_valid_writes"}, 139'(nvalid), 139'(m_fwd));
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    mon_en = 1'b0;
    for (int i = 0; i < P; i++) begin
      pwr[i] = 0; prd[i] = 0; vwr[i] = 0; vrd[i] = 0;
      npk[i] = 0; m_pk[i] = 0; m_woff[i] = 0;
    end
    hide = '0; m_ptr = 0; m_fwd = 0; m_drop = 0; nvalid = 0;
    expq.delete();
    expg.delete();
    await_wr = 1'b0; prev_tail = 1'b0; last_vrd_cyc = -1;
    drive();
    cyc();
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_strobes"},
        139'({in_pkt_rdreq, in_valid_rdreq, out_pkt_wrreq, out_valid_wrreq}), 139'(0));
    chk({tag, "_grant"}, 139'(grant), 139'(0));
    chk({tag, "_counters"}, 139'({fwd_cnt, drop_cnt}), 139'(0));
    chk({tag, "_out_pkt"}, out_pkt, 139'(0));
    chk({tag, "_out_valid"}, 139'(out_valid), 139'(0));
  endtask

  initial begin
    int           n, seen, c0, gap_bad;
    logic [P-1:0] exp_rd;
    nchk = 0; npass = 0; cycle = 0; wr_lat = -1;
    hide = '0; rand_used = 1'b0; rand_hide = 1'b0; mon_en = 1'b0;
    out_pkt_usedw = 8'd0;

    // {valid_empty, valid_q, usedw, granted, grant} with rr_ptr = 0 after reset
    tbl[0] = '{4'b1110, 4'b0001, 8'd0,   1'b1, 3'd0};
    tbl[1] = '{4'b1001, 4'b0110, 8'd100, 1'b1, 3'd1};
    tbl[2] = '{4'b0111, 4'b1000, 8'd160, 1'b1, 3'd3};
    tbl[3] = '{4'b0111, 4'b1000, 8'd161, 1'b0, 3'd0};
    tbl[4] = '{4'b0111, 4'b0000, 8'd255, 1'b1, 3'd3};
    tbl[5] = '{4'b1111, 4'b0000, 8'd0,   1'b0, 3'd0};
    tbl[6] = '{4'b0011, 4'b0100, 8'd200, 1'b0, 3'd0};
    tbl[7] = '{4'b0000, 4'b0000, 8'd161, 1'b1, 3'd0};

    do_reset();
    check_reset("por");

    // Grant decision table: observe grant and the valid pop in the cycle after IDLE.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      mon_en = 1'b0;
      out_pkt_usedw = tbl[t].used;
      for (int i = 0; i < P; i++) if (!tbl[t].vempty[i]) add_pkt(i, tbl[t].vq[i], 1, -1);
      cyc();
      cyc();
      exp_rd = '0;
      if (tbl[t].granted) exp_rd[tbl[t].g] = 1'b1;
      chk($sformatf("tbl%0d_valid_rdreq", t), 139'(s_vrd), 139'(exp_rd));
      chk($sformatf("tbl%0d_grant", t), 139'(grant), 139'(tbl[t].granted ? tbl[t].g : 3'd0));
    end
    out_pkt_usedw = 8'd0;

    // Single 3-word packet on port 0, tail byte count 7.
    do_reset();
    add_pkt(0, 1'b1, 3, 7);
    model_run();
    run_until("single", 50);
    chk("first_word_latency", 139'(wr_lat), 139'(2));

    // Dropped 4-word packet on port 1 followed by a forwarded one.
    do_reset();
    add_pkt(1, 1'b0, 4, -1);
    add_pkt(1, 1'b1, 2, -1);
    model_run();
    run_until("drop", 60);
    chk("drop_pkt_pops", 139'(prd[1]), 139'(6));
    chk("drop_valid_pops", 139'(vrd[1]), 139'(2));

    // Round robin over all ports, then wrap-around with ports 0 and 2 pending.
    do_reset();
    for (int i = 0; i < P; i++) add_pkt(i, 1'b1, 1, -1);
    model_run();
    run_until("rr4", 60);
    add_pkt(2, 1'b1, 1, -1);
    add_pkt(0, 1'b1, 1, -1);
    model_run();
    run_until("wrap", 40);

    // Output fill threshold.
    do_reset();
    out_pkt_usedw = 8'd161;
    add_pkt(0, 1'b1, 4, -1);
    model_run();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (s_vrd != '0) seen++;
    end
    chk("thresh_hold", 139'(seen), 139'(0));
    out_pkt_usedw = 8'd160;
    c0 = cycle;
    cyc();
    cyc();
    chk("thresh_release", 139'(last_vrd_cyc), 139'(c0 + 2));
    out_pkt_usedw = 8'd200;
    run_until("thresh_inflight", 40);
    out_pkt_usedw = 8'd0;

    // 5-cycle empty gap on the granted packet FIFO after two words have been popped.
    do_reset();
    add_pkt(0, 1'b1, 5, -1);
    model_run();
    n = 0;
    while (prd[0] < 2 && n < 30) begin
      cyc();
      n++;
    end
    chk("gap_reached", 139'(prd[0]), 139'(2));
    hide[0] = 1'b1;
    drive();
    gap_bad = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (s_prd != '0) gap_bad++;
      if (k > 0 && s_wr) gap_bad++;
    end
    chk("gap_quiet", 139'(gap_bad), 139'(0));
    hide[0] = 1'b0;
    drive();
    run_until("gap", 40);

    // Reset in the middle of a transfer, then a normal packet.
    do_reset();
    add_pkt(0, 1'b1, 8, -1);
    model_run();
    n = 0;
    while (prd[0] < 3 && n < 30) begin
      cyc();
      n++;
    end
    chk("mid_xfer_reached", 139'(prd[0]), 139'(3));
    do_reset();
    check_reset("mid_xfer");
    add_pkt(0, 1'b1, 2, -1);
    model_run();
    run_until("after_reset", 40);

    // Randomized traffic with fill-level jitter and packet FIFO empty gaps.
    do_reset();
    rand_used = 1'b1;
    rand_hide = 1'b1;
    for (int k = 0; k < 30; k++)
      add_pkt($urandom_range(0, P - 1), ($urandom_range(0, 3) != 0), $urandom_range(1, 4), -1);
    model_run();
    run_until("random1", 3000);
    for (int k = 0; k < 20; k++)
      add_pkt($urandom_range(0, P - 1), ($urandom_range(0, 3) != 0), $urandom_range(1, 4), -1);
    model_run();
    run_until("random2", 3000);
    rand_used = 1'b0;
    rand_hide = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/nmac_port_arbiter.md
Name: nmac_port_arbiter

Overview:
- Round-robin scheduler merging the per-port CRC-checked packet streams (139-bit packet FIFO plus 1-bit valid FIFO per port) into one shared output packet/valid FIFO pair.
- Sits between the per-port CRC check stages and the common output FIFO.
- Forwards packets whose valid word is 1 and drains packets whose valid word is 0.
- Keeps per-block forward and drop counters.

Parameters:
- PORTS, 4, number of requesting ports (2..8).
- USEDW_THRESH, 8'd161, start a new forwarded packet only while out_pkt_usedw < USEDW_THRESH.

Ports:
- clk  in  1  single clock for all logic; all input FIFO read sides and the output FIFO write side run on it.
- reset  in  1  synchronous, active-high reset.
- in_pkt_q  in  PORTS*139  show-ahead packet FIFO heads; port i occupies bits [139*i+138:139*i].
- in_pkt_empty  in  PORTS  packet FIFO empty flags.
- in_pkt_rdreq  out  PORTS  packet FIFO pops, combinational.
- in_valid_q  in  PORTS  show-ahead valid FIFO heads.
- in_valid_empty  in  PORTS  valid FIFO empty flags.
- in_valid_rdreq  out  PORTS  valid FIFO pops, registered.
- out_pkt_wrreq  out  1  output packet write strobe.
- out_pkt  out  139  output packet word.
- out_pkt_usedw  in  8  output packet FIFO fill level.
- out_valid_wrreq  out  1  output valid write strobe.
- out_valid  out  1  output valid word (always 1 when written).
- grant  out  3  index of the port currently owned; 0 when idle.
- fwd_cnt  out  16  forwarded packets, saturating at 16'hFFFF.
- drop_cnt  out  16  dropped packets, saturating.

Behaviour:
- Word format: [138:136] = 101 header, 100 middle, 110 tail, 111 single-word packet (header and tail); [135:132] = tail valid-byte count minus 1. Words pass through unmodified.
- Reset: state IDLE, rr_ptr=0, grant=0; all wrreq/rdreq low; out_pkt=0, out_valid=0; counters 0. Reset mid-packet abandons the packet; the surrounding FIFOs are cleared by the system reset.
- States: IDLE, SEL, XFER, DROP, DONE.
- IDLE:
  - Request vector: req[i] = !in_valid_empty[i].
  - Pick the first requesting port at or after rr_ptr, wrapping around.
  - If in_valid_q of the winner is 1 and out_pkt_usedw >= USEDW_THRESH, do not grant; stay in IDLE. Dropped packets (valid=0) ignore the threshold.
  - On grant: latch grant, pulse in_valid_rdreq[grant] for 1 cycle, latch the valid bit, go to SEL.
- SEL (1 cycle, allows the valid FIFO pop to settle): go to XFER if the latched valid bit is 1, else DROP.
- XFER:
  - in_pkt_rdreq[grant] = !in_pkt_empty[grant].
  - On each pop, the next cycle has out_pkt_wrreq=1 and out_pkt = the popped word.
  - Empty FIFO mid-packet: stall with no write; this is not an error.
  - Popping a word with type 110 or 111 goes to DONE.
- DROP: same popping rule with no output writes; popping a 110 or 111 word goes to DONE.
- DONE (1 cycle):
  - For a forwarded packet: out_valid_wrreq=1 and out_valid=1, landing 1 cycle after the tail write; fwd_cnt++.
  - For a dropped packet: drop_cnt++.
  - rr_ptr = grant+1 modulo PORTS; go to IDLE.
- Latency: the first output word appears 3 cycles after the IDLE grant cycle, given a non-empty FIFO. Minimum per-packet overhead is 3 cycles (IDLE, SEL, DONE).
- Only the granted port ever sees rdreq; there is never more than one rdreq bit set.
- Malformed input: a header word seen mid-packet is passed through; no resynchronisation.
- Threshold is sampled only at grant; a packet in progress is never paused by usedw.

Test Plan:
- Single port 0, 3-word packet (101, 100, 110 with [135:132]=4'h7), valid=1 → 3 out_pkt writes identical to input, then out_valid_wrreq with out_valid=1 one cycle after the tail write; fwd_cnt=1.
- Port 1, valid=0, 4-word packet → 4 pkt pops, 1 valid pop, no output writes; drop_cnt=1; next port 1 packet starts at its header.
- All 4 ports hold one 1-word (111) valid=1 packet each, rr_ptr=0 → grants in order 0,1,2,3; then port 0 refilled with port 2 also pending after grant 3 → port 0 is granted next (wrap-around).
- out_pkt_usedw=161 with port 0 valid=1 pending → no grant for 20 cycles. Drop usedw to 160 → grant within 1 cycle. Raise usedw to 200 mid-packet → packet completes.
- Empty pulse on the granted packet FIFO for 5 cycles mid-packet → no write and no rdreq during the gap; word order preserved.
- reset asserted for 1 cycle during XFER → next cycle all strobes are 0, state IDLE, counters 0; the following packet is forwarded normally.
